eq_frame_sequencer: RTL

EQ_FRAME_SEQUENCER -- requirements
Module: eq_frame_sequencer

---
 rtl/eq_pkg.sv | 17 +
 rtl/eq_frame_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared state encoding and default latencies for the equalizer frame sequencer
package eq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_CH = 3'd1,
        ST_SETUP   = 3'd2,
        ST_DATA    = 3'd3,
        ST_DRAIN   = 3'd4
    } eq_state_t;

    localparam int DEF_DATASYMS     = 12;
    localparam int DEF_COEF_LATENCY = 13;
    localparam int DEF_DRAIN_CYCLES = 6;
    localparam int DEF_TIMEOUT      = 1024;

endpackage

// File: rtl/eq_frame_sequencer.sv
// rtl/eq_frame_sequencer.sv - gates channel-estimate and data-symbol valids into the equalizer per frame
module eq_frame_sequencer
    import eq_pkg::*;
#(
    parameter int DATASYMS     = DEF_DATASYMS,
    parameter int COEF_LATENCY = DEF_COEF_LATENCY,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_start_i,
    input  logic                        chest_valid_i,
    input  logic                        sym_valid_i,
    input  logic                        abort_i,
    output logic                        eq_chest_valid_o,
    output logic                        eq_sym_valid_o,
    output logic [$clog2(DATASYMS)-1:0] sym_idx_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic [1:0]                  err_o
);

    localparam int IDX_W  = $clog2(DATASYMS);
    localparam int PH_MAX = (COEF_LATENCY > DRAIN_CYCLES) ? COEF_LATENCY : DRAIN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int GAP_W  = $clog2(TIMEOUT) + 1;

    localparam logic [IDX_W-1:0] LAST_SYM   = IDX_W'(DATASYMS - 1);
    localparam logic [PH_W-1:0]  SETUP_LOAD = PH_W'(COEF_LATENCY - 1);
    localparam logic [PH_W-1:0]  DRAIN_LOAD = PH_W'(DRAIN_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_TC     = GAP_W'(TIMEOUT - 1);

    eq_state_t        state, state_nx;
    logic [GAP_W-1:0] gap, gap_nx;
    logic [PH_W-1:0]  ph, ph_nx;
    logic [IDX_W-1:0] cnt, cnt_nx, idx_nx;
    logic [1:0]       err_nx;
    logic             chv_nx, syv_nx, done_nx, accept;

    always_comb begin
        state_nx = state;
        gap_nx   = gap;
        ph_nx    = ph;
        cnt_nx   = cnt;
        idx_nx   = sym_idx_o;
        err_nx   = err_o;
        chv_nx   = 1'b0;
        syv_nx   = 1'b0;
        done_nx  = 1'b0;
        accept   = 1'b0;

        if (abort_i) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        state_nx = ST_WAIT_CH;
                        err_nx   = 2'b00;
                        gap_nx   = '0;
                    end
                end
                ST_WAIT_CH: begin
                    if (chest_valid_i) begin
                        chv_nx   = 1'b1;
                        state_nx = ST_SETUP;
                        ph_nx    = SETUP_LOAD;
                        gap_nx   = '0;
                    end else if (gap == GAP_TC) begin
                        err_nx[0] = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        gap_nx = gap + 1'b1;
                    end
                end
                ST_SETUP: begin
                    // A symbol on the terminal-count cycle reaches the equalizer
                    // exactly when the reciprocals settle, so it is not early.
                    if (ph == '0) begin
                        state_nx = ST_DATA;
                        cnt_nx   = '0;
                        gap_nx   = '0;
                        accept   = sym_valid_i;
                    end else if (sym_valid_i) begin
                        err_nx[1] = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        ph_nx = ph - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sym_valid_i) begin
                        accept = 1'b1;
                    end else if (gap == GAP_TC) begin
                        err_nx[0] = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        gap_nx = gap + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ph == '0) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        ph_nx = ph - 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        if (accept) begin
            syv_nx = 1'b1;
            idx_nx = cnt_nx;
            gap_nx = '0;
            if (cnt_nx == LAST_SYM) begin
                cnt_nx   = '0;
                state_nx = ST_DRAIN;
                ph_nx    = DRAIN_LOAD;
            end else begin
                cnt_nx = cnt_nx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state            <= ST_IDLE;
            gap              <= '0;
            ph               <= '0;
            cnt              <= '0;
            eq_chest_valid_o <= 1'b0;
            eq_sym_valid_o   <= 1'b0;
            sym_idx_o        <= '0;
            busy_o           <= 1'b0;
            frame_done_o     <= 1'b0;
            err_o            <= 2'b00;
        end else begin
            state            <= state_nx;
            gap              <= gap_nx;
            ph               <= ph_nx;
            cnt              <= cnt_nx;
            eq_chest_valid_o <= chv_nx;
            eq_sym_valid_o   <= syv_nx;
            sym_idx_o        <= idx_nx;
            busy_o           <= (state_nx != ST_IDLE);
            frame_done_o     <= done_nx;
            err_o            <= err_nx;
        end
    end

endmodule
